seq_shifter: RTL and testbench
==============================

# seq_shifter

Multi-cycle, parametrised shift/rotate unit for the ALU datapath: the next generation of the single-cycle left shifter. It adds four shift modes, configurable data width and bits-shifted-per-cycle, a carry-out flag, and valid/ready handshakes on both sides. It sits beside the other ALU function units and feeds B plus the Z/N/CY flags to the result mux and status register.

## Interface
- WIDTH, 32, data width; power of two, ≥ 4
- STEP, 1, maximum bits shifted per SHIFT cycle; power of two, 1..WIDTH
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  operands/mode valid
- in_ready  out  1  unit can accept (IDLE only)
- A  in  WIDTH  operand to shift
- C  in  WIDTH  shift amount, unsigned, full width
- mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result
- B  out  WIDTH  result
- Z  out  1  B == 0
- N  out  1  B[WIDTH-1]
- CY  out  1  last bit shifted/rotated out

## Operation
- One clock domain, asynchronous active-low reset.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch A, mode and effective count E.
  - LSL/LSR/ASR: E = min(C, WIDTH+1).
  - ROR: E = C mod WIDTH.
  - Clear CY. Next state is SHIFT if E>0, else DONE.
- SHIFT: each cycle shift the working register by k = min(remaining, STEP) and subtract k from remaining. CY is the last bit moved out in this chunk:
  - LSL: fill 0; CY = bit that was at position WIDTH-k.
  - LSR: fill 0; CY = bit that was at position k-1.
  - ASR: fill sign bit; CY = bit that was at position k-1.
  - ROR: rotate right; CY = new B[WIDTH-1].
  - Go to DONE when remaining reaches 0.
- Consequences of the clamp to WIDTH+1:
  - LSL/LSR: C=WIDTH gives B=0 with CY = A[0] (LSL) or A[WIDTH-1] (LSR). C>WIDTH gives B=0, CY=0.
  - ASR: C≥WIDTH gives B = all sign bits, CY = sign.
- DONE: out_valid=1. B, Z, N and CY are registered and held stable. in_ready=0.
  - On out_ready, go to IDLE; out_valid drops on the next cycle.
- E=0 (C=0, or ROR with C a multiple of WIDTH): B=A, CY=0.
- Z/N are computed from the final B when entering DONE.
- B/Z/N/CY keep their last value after the handshake. They are meaningful only while out_valid=1.
- in_valid is ignored outside IDLE. No new operation is accepted in the cycle of the output handshake.

## Timing
- Reset values: in_ready=1, out_valid=0, B=0, Z=0, N=0, CY=0, state IDLE.
- Reset asserted mid-SHIFT or in DONE: immediate return to IDLE with the reset values. The in-flight operation is discarded.
- Latency: out_valid rises ceil(E/STEP)+1 cycles after the accepting edge.
  - E=0: 1 cycle.
  - WIDTH=32, STEP=1, LSL/LSR/ASR worst case (E=33): 34 cycles.
- Throughput: one operation per ceil(E/STEP)+2 cycles with out_ready held high.
- Outputs are stable from out_valid rise until the out_ready handshake edge. No combinational path from inputs to outputs.

## Test plan
Default configuration is WIDTH=32, STEP=1 unless noted.
- LSL, A=0x00000001, C=4 → B=0x00000010, Z=0, N=0, CY=0; out_valid 5 cycles after accept. With C=0 and A=0x80000001 → B=0x80000001, N=1, CY=0, out_valid after 1 cycle.
- LSR, A=0x80000000:
  - C=32 → B=0, Z=1, CY=1, latency 33.
  - C=33 → B=0, CY=0.
  - C=0xFFFFFFFF → B=0, CY=0, latency 34.
- ASR, A=0x80000000, C=40 → B=0xFFFFFFFF, N=1, Z=0, CY=1. ROR, A=0x00000001, C=33 → B=0x80000000, N=1, CY=1, latency 2.
- STEP=8: LSL, A=0x000000FF, C=20 → B=0x0FF00000, CY=0, latency 4. ROR, A=0x12345678, C=8 → B=0x78123456, CY=0, latency 2.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and A.
  - Required: B/flags stable, in_ready=0, no new accept.
  - On release: out_valid=0 and in_ready=1 on the next cycle.
- Assert rst_n=0 midway through a C=20 shift → all outputs take their reset values immediately. After release, a new LSL A=3, C=1 → B=6.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit (LSL/LSR/ASR/ROR) with carry-out and Z/N flags.
// Latency: out_valid rises ceil(E/STEP)+1 cycles after accept (E = effective count).
// Backpressure: result is held in DONE until out_ready; in_ready is high only in IDLE.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (A, C, mode)
//   A                    operand, C unsigned shift amount, mode 00 LSL 01 LSR 10 ASR 11 ROR
//   out_valid/out_ready  result handshake
//   B, Z, N, CY          result, zero, negative, last bit shifted/rotated out
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] C,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] B,
    output logic             Z,
    output logic             N,
    output logic             CY
);
    // Count register holds 0..WIDTH+1, one bit wider than a bit index.
    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;

    localparam logic [CW-1:0]    EMAX    = CW'(WIDTH + 1);
    localparam logic [WIDTH-1:0] EMAX_W  = WIDTH'(WIDTH + 1);
    localparam logic [CW-1:0]    STEP_C  = CW'(STEP);
    localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0]    ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        M_LSL = 2'b00,
        M_LSR = 2'b01,
        M_ASR = 2'b10,
        M_ROR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state;
    mode_e         md;
    logic [CW-1:0] rem;

    // Effective count at accept. Shifts clamp to WIDTH+1 so that C=WIDTH still
    // reports the last real bit in CY while anything larger drains CY to the fill.
    logic [CW-1:0] e_in;
    always_comb begin
        e_in = '0;
        if (mode == M_ROR)
            e_in = {1'b0, C[LW-1:0]};
        else if (C > EMAX_W)
            e_in = EMAX;
        else
            e_in = C[CW-1:0];
    end

    // One chunk of up to STEP bits. B doubles as the working register while
    // shifting; its value is only meaningful once out_valid is set.
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] lsl_v, lsr_v, asr_v, ror_v;
    logic [WIDTH-1:0] lsl_m1, lsr_m1;
    logic [WIDTH-1:0] sh_nxt;
    logic             cy_nxt;

    always_comb begin
        k      = (rem < STEP_C) ? rem : STEP_C;
        lsl_v  = B << k;
        lsr_v  = B >> k;
        asr_v  = $unsigned($signed(B) >>> k);
        ror_v  = (B >> k) | (B << (WIDTH_C - k));
        // Shifting by k-1 brings the last bit to leave into the edge position.
        lsl_m1 = B << (k - ONE_C);
        lsr_m1 = B >> (k - ONE_C);
        sh_nxt = lsl_v;
        cy_nxt = 1'b0;
        case (md)
            M_LSL: begin sh_nxt = lsl_v; cy_nxt = lsl_m1[WIDTH-1]; end
            M_LSR: begin sh_nxt = lsr_v; cy_nxt = lsr_m1[0];       end
            M_ASR: begin sh_nxt = asr_v; cy_nxt = lsr_m1[0];       end
            M_ROR: begin sh_nxt = ror_v; cy_nxt = ror_v[WIDTH-1];  end
            default: begin sh_nxt = lsl_v; cy_nxt = 1'b0;          end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            md        <= M_LSL;
            rem       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            B         <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
            CY        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        B        <= A;
                        md       <= mode_e'(mode);
                        rem      <= e_in;
                        CY       <= 1'b0;
                        in_ready <= 1'b0;
                        if (e_in == '0) begin
                            // Nothing to shift: result is A itself.
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            Z         <= (A == '0);
                            N         <= A[WIDTH-1];
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    B   <= sh_nxt;
                    CY  <= cy_nxt;
                    rem <= rem - k;
                    if (rem == k) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        Z         <= (sh_nxt == '0);
                        N         <= sh_nxt[WIDTH-1];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: two instances (STEP=1 and STEP=8, WIDTH=32) with
// shared operand buses and private handshakes, checked against a plain
// arithmetic model of the shift rules.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] c_in = '0;
    logic [1:0]  mode_in = '0;
    logic [1:0]  iv = '0;
    logic [1:0]  ordy = '0;

    logic        ir1, ov1, z1, n1, cy1;
    logic [31:0] b1;
    logic        ir8, ov8, z8, n8, cy8;
    logic [31:0] b8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir1),
        .A(a_in), .C(c_in), .mode(mode_in),
        .out_valid(ov1), .out_ready(ordy[0]),
        .B(b1), .Z(z1), .N(n1), .CY(cy1)
    );

    seq_shifter #(.WIDTH(32), .STEP(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir8),
        .A(a_in), .C(c_in), .mode(mode_in),
        .out_valid(ov8), .out_ready(ordy[1]),
        .B(b8), .Z(z8), .N(n8), .CY(cy8)
    );

    // Outputs of the currently selected instance.
    logic        cur = 1'b0;
    logic        s_ir, s_ov, s_z, s_n, s_cy;
    logic [31:0] s_b;
    always_comb begin
        s_ir = cur ? ir8 : ir1;
        s_ov = cur ? ov8 : ov1;
        s_b  = cur ? b8  : b1;
        s_z  = cur ? z8  : z1;
        s_n  = cur ? n8  : n1;
        s_cy = cur ? cy8 : cy1;
    end

    typedef struct {
        logic [31:0] b;
        logic        z;
        logic        n;
        logic        cy;
        int          lat;
    } res_t;

    // Reference: whole-operation arithmetic on a 64-bit window, no stepping.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] c,
                                   input logic [1:0] m, input int step);
        res_t r;
        logic [63:0]        t;
        logic signed [63:0] s;
        int e;
        int rr;
        r.b = a; r.cy = 1'b0;
        case (m)
            2'b00: begin
                e = (c > 32'd33) ? 33 : int'(c);
                if (c <= 32'd32) begin
                    t = {32'h0, a} << c;
                    r.b = t[31:0]; r.cy = t[32];
                end else begin
                    r.b = '0; r.cy = 1'b0;
                end
            end
            2'b01: begin
                e = (c > 32'd33) ? 33 : int'(c);
                if (c <= 32'd32) begin
                    t = {a, 32'h0} >> c;
                    r.b = t[63:32]; r.cy = t[31];
                end else begin
                    r.b = '0; r.cy = 1'b0;
                end
            end
            2'b10: begin
                e = (c > 32'd33) ? 33 : int'(c);
                if (c <= 32'd32) begin
                    s = {a, 32'h0};
                    s = s >>> c;
                    r.b = s[63:32]; r.cy = s[31];
                end else begin
                    r.b = {32{a[31]}}; r.cy = a[31];
                end
            end
            default: begin
                rr = int'(c % 32);
                e = rr;
                if (rr != 0) begin
                    r.b = (a >> rr) | (a << (32 - rr));
                    r.cy = r.b[31];
                end
            end
        endcase
        r.z = (r.b == 32'h0);
        r.n = r.b[31];
        r.lat = (e + step - 1) / step + 1;
        return r;
    endfunction

    // Issue one operation on instance sel, return observed result and latency
    // (cycles from accepting edge to the edge where out_valid is first seen).
    task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] c,
                          input logic [1:0] m, output res_t r);
        int w;
        cur = sel; a_in = a; c_in = c; mode_in = m;
        ordy[sel] = 1'b0;
        iv[sel] = 1'b1;
        w = 0;
        while (!s_ir && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, required 1", s_ir, w);
        end
        @(posedge clk);
        #1 iv[sel] = 1'b0;
        r.lat = 1;
        @(negedge clk);
        while (!s_ov && r.lat < 200) begin
            @(negedge clk);
            r.lat++;
        end
        r.b = s_b; r.z = s_z; r.n = s_n; r.cy = s_cy;
        ordy[sel] = 1'b1;
        @(negedge clk);
        ordy[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({ir1, ov1} !== 2'b10) begin n_bad++; $display("FAIL reset_hs1: ir/ov=%b required 10", {ir1, ov1}); end
        n_cmp++; if ({b1, z1, n1, cy1} !== 35'h0) begin n_bad++; $display("FAIL reset_out1: B=%h ZNC=%b%b%b required 0", b1, z1, n1, cy1); end
        n_cmp++; if ({ir8, ov8} !== 2'b10) begin n_bad++; $display("FAIL reset_hs8: ir/ov=%b required 10", {ir8, ov8}); end
        n_cmp++; if ({b8, z8, n8, cy8} !== 35'h0) begin n_bad++; $display("FAIL reset_out8: B=%h ZNC=%b%b%b required 0", b8, z8, n8, cy8); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({ir1, ov1, ir8, ov8} !== 4'b1010) begin n_bad++; $display("FAIL reset_release: %b required 1010", {ir1, ov1, ir8, ov8}); end
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] a;
        logic [31:0] c;
        logic [1:0]  m;
        logic [31:0] b;
        logic        z;
        logic        n;
        logic        cy;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[12];
        res_t r;
        v[0]  = '{1'b0, 32'h00000001, 32'd4,        2'b00, 32'h00000010, 1'b0, 1'b0, 1'b0, 5};
        v[1]  = '{1'b0, 32'h80000001, 32'd0,        2'b00, 32'h80000001, 1'b0, 1'b1, 1'b0, 1};
        v[2]  = '{1'b0, 32'h80000000, 32'd32,       2'b01, 32'h00000000, 1'b1, 1'b0, 1'b1, 33};
        v[3]  = '{1'b0, 32'h80000000, 32'd33,       2'b01, 32'h00000000, 1'b1, 1'b0, 1'b0, 34};
        v[4]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 2'b01, 32'h00000000, 1'b1, 1'b0, 1'b0, 34};
        v[5]  = '{1'b0, 32'h80000000, 32'd40,       2'b10, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 34};
        v[6]  = '{1'b0, 32'h00000001, 32'd33,       2'b11, 32'h80000000, 1'b0, 1'b1, 1'b1, 2};
        v[7]  = '{1'b0, 32'h80000001, 32'd32,       2'b00, 32'h00000000, 1'b1, 1'b0, 1'b1, 33};
        v[8]  = '{1'b1, 32'h000000FF, 32'd20,       2'b00, 32'h0FF00000, 1'b0, 1'b0, 1'b0, 4};
        v[9]  = '{1'b1, 32'h12345678, 32'd8,        2'b11, 32'h78123456, 1'b0, 1'b0, 1'b0, 2};
        v[10] = '{1'b1, 32'h80000000, 32'd33,       2'b10, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 6};
        v[11] = '{1'b1, 32'h80000000, 32'd32,       2'b01, 32'h00000000, 1'b1, 1'b0, 1'b1, 5};
        foreach (v[i]) begin
            run_op(v[i].sel, v[i].a, v[i].c, v[i].m, r);
            n_cmp++;
            if ({r.b, r.z, r.n, r.cy} !== {v[i].b, v[i].z, v[i].n, v[i].cy}) begin
                n_bad++;
                $display("FAIL dir%0d_result: B=%h ZNC=%b%b%b required B=%h ZNC=%b%b%b",
                         i, r.b, r.z, r.n, r.cy, v[i].b, v[i].z, v[i].n, v[i].cy);
            end
            n_cmp++;
            if (r.lat != v[i].lat) begin
                n_bad++;
                $display("FAIL dir%0d_latency: %0d required %0d", i, r.lat, v[i].lat);
            end
        end
    endtask

    task automatic test_random();
        res_t r, e;
        logic [31:0] a, c;
        logic [1:0]  m;
        logic        sel;
        for (int i = 0; i < 60; i++) begin
            sel = (i % 2 == 1);
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h0;
            m = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            e = model(a, c, m, sel ? 8 : 1);
            run_op(sel, a, c, m, r);
            n_cmp++;
            if ({r.b, r.z, r.n, r.cy} !== {e.b, e.z, e.n, e.cy}) begin
                n_bad++;
                $display("FAIL rnd%0d_result: step=%0d mode=%0d A=%h C=%h B=%h ZNC=%b%b%b required B=%h ZNC=%b%b%b",
                         i, sel ? 8 : 1, m, a, c, r.b, r.z, r.n, r.cy, e.b, e.z, e.n, e.cy);
            end
            n_cmp++;
            if (r.lat != e.lat) begin
                n_bad++;
                $display("FAIL rnd%0d_latency: %0d required %0d", i, r.lat, e.lat);
            end
        end
    endtask

    task automatic test_backpressure();
        res_t e;
        int w;
        cur = 1'b0;
        a_in = 32'h0F0F1234; c_in = 32'd5; mode_in = 2'b00;
        e = model(32'h0F0F1234, 32'd5, 2'b00, 1);
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        w = 0;
        @(negedge clk);
        while (!ov1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({ov1, ir1, b1, z1, n1, cy1} !== {2'b10, e.b, e.z, e.n, e.cy}) begin
                n_bad++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b B=%h ZNC=%b%b%b required ov=1 ir=0 B=%h ZNC=%b%b%b",
                         i, ov1, ir1, b1, z1, n1, cy1, e.b, e.z, e.n, e.cy);
            end
            iv[0] = ~iv[0];
            a_in = $urandom;
            @(negedge clk);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ov1, ir1} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_release: ov=%b ir=%b required ov=0 ir=1", ov1, ir1);
        end
        ordy[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int w;
        cur = 1'b0;
        a_in = 32'h1; c_in = 32'd3; mode_in = 2'b01;
        ordy[0] = 1'b1;
        iv[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (ir1) acc.push_back(i);
            @(negedge clk);
        end
        iv[0] = 1'b0;
        w = 0;
        while (!(ir1 && !ov1) && w < 100) begin
            @(negedge clk);
            w++;
        end
        ordy[0] = 1'b0;
        n_cmp++;
        if (acc.size() < 3) begin
            n_bad++;
            $display("FAIL b2b_count: %0d accepts required at least 3", acc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (acc[i] - acc[i-1] != 5) begin
                    n_bad++;
                    $display("FAIL b2b_period%0d: %0d cycles required 5", i, acc[i] - acc[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_midshift();
        res_t r;
        cur = 1'b0;
        a_in = 32'hFFFF0000; c_in = 32'd20; mode_in = 2'b00;
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ir1, ov1, b1, z1, n1, cy1} !== {2'b10, 35'h0}) begin
            n_bad++;
            $display("FAIL midreset: ir=%b ov=%b B=%h ZNC=%b%b%b required ir=1 ov=0 B=0 ZNC=000",
                     ir1, ov1, b1, z1, n1, cy1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 32'd3, 32'd1, 2'b00, r);
        n_cmp++;
        if ({r.b, r.cy} !== {32'd6, 1'b0} || r.lat != 2) begin
            n_bad++;
            $display("FAIL post_reset_op: B=%h CY=%b lat=%0d required B=00000006 CY=0 lat=2", r.b, r.cy, r.lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midshift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
